instr_trace_queue: RTL

INSTR_TRACE_QUEUE -- requirements
Module: instr_trace_queue

---
 rtl/instr_trace_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instr_trace_queue.sv
// Instruction trace queue: records fetched PCs in order and checks each retiring PC
// against the oldest in-flight entry, with sticky overflow/underflow/mismatch flags.
module instr_trace_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_valid,
  input  logic [ADDR_WIDTH-1:0]        fetch_pc,
  input  logic                         retire_valid,
  input  logic [ADDR_WIDTH-1:0]        retire_pc,
  input  logic                         flush,
  output logic                         head_valid,
  output logic [ADDR_WIDTH-1:0]        head_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow_err,
  output logic                         underflow_err,
  output logic                         mismatch_err,
  output logic [ADDR_WIDTH-1:0]        mismatch_pc,
  output logic [CNT_WIDTH-1:0]         retired_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         pushIdx;
  logic [CW-1:0]         count_q, count_d;
  logic [CNT_WIDTH-1:0]  retiredCnt_q, retiredCnt_d;
  logic [ADDR_WIDTH-1:0] mismatchPc_q, mismatchPc_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  mismatch_q, mismatch_d;
  logic                  isEmpty, isFull;
  logic                  retireAcc, pushAcc, pcMiss;

  // Events resolve as pop, then flush, then push; a flush therefore frees room for a fetch.
  always_comb begin
    isEmpty      = (count_q == '0);
    isFull       = (count_q == FULL_CNT);
    retireAcc    = retire_valid && !isEmpty;
    pushAcc      = fetch_valid && (!isFull || retireAcc || flush);
    pcMiss       = retireAcc && (retire_pc != mem_q[rdPtr_q]);

    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    count_d      = count_q;
    retiredCnt_d = retiredCnt_q;
    mismatchPc_d = mismatchPc_q;
    overflow_d   = overflow_q  | (fetch_valid && !pushAcc);
    underflow_d  = underflow_q | (retire_valid && isEmpty);
    mismatch_d   = mismatch_q  | pcMiss;

    if (retireAcc) begin
      rdPtr_d      = rdPtr_q + PW'(1);
      count_d      = count_q - CW'(1);
      retiredCnt_d = retiredCnt_q + CNT_WIDTH'(1);
    end
    if (pcMiss && !mismatch_q) begin
      mismatchPc_d = mem_q[rdPtr_q];
    end
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end
    pushIdx = wrPtr_d;
    if (pushAcc) begin
      wrPtr_d = wrPtr_d + PW'(1);
      count_d = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
      retiredCnt_q <= '0;
      mismatchPc_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
      retiredCnt_q <= retiredCnt_d;
      mismatchPc_q <= mismatchPc_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      mismatch_q   <= mismatch_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (pushAcc) begin
      mem_q[pushIdx] <= fetch_pc;
    end
  end

  assign head_valid    = !isEmpty;
  assign head_pc       = mem_q[rdPtr_q];
  assign count         = count_q;
  assign full          = isFull;
  assign empty         = isEmpty;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;
  assign mismatch_err  = mismatch_q;
  assign mismatch_pc   = mismatchPc_q;
  assign retired_cnt   = retiredCnt_q;

endmodule
